// File: rtl/decode_bundle_stage.sv
// decode_bundle_stage: registered multi-lane decode with RAW split,
// taken-branch squash and predicted-taken non-branch flag.

module decoder #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19
) (
  input  logic [XLEN-1:0]   i_inst,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_is_cf,
  output logic              o_writes,
  output logic              o_rd1,
  output logic              o_rd2,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_rs1,
  output logic [4:0]        o_rs2
);
  logic [6:0]  w_op;
  logic [18:0] w_core;
  logic        w_unused;

  assign w_op     = i_inst[6:0];
  assign o_rd     = i_inst[11:7];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign w_unused = ^{i_inst[XLEN-1:25], i_inst[14:12]};

  // per-lane register usage and control-flow class
  always_comb begin
    o_is_cf  = (w_op == 7'b1100011) || (w_op == 7'b1101111) ||
               (w_op == 7'b1100111);
    o_writes = (w_op != 7'b1100011) && (w_op != 7'b0100011) &&
               (o_rd != 5'd0);
    o_rd1    = (w_op != 7'b0110111) && (w_op != 7'b0010111) &&
               (w_op != 7'b1101111);
    o_rd2    = (w_op == 7'b1100011) || (w_op == 7'b0100011) ||
               (w_op == 7'b0110011);
  end

  assign w_core = {o_is_cf, o_writes, o_rd1, o_rd2, o_rs2, o_rs1, o_rd};
  assign o_ctrl = CTRL_W'(w_core);
endmodule

module decode_bundle_stage #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*XLEN-1:0]     inst_i,
  input  logic [LANES-1:0]          lane_valid_i,
  input  logic [LANES-1:0]          pred_taken_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*XLEN-1:0]     inst_o,
  output logic [LANES*CTRL_W-1:0]   ctrl_o,
  output logic [LANES-1:0]          lane_valid_o,
  output logic                      wasnt_branch_o,
  output logic [$clog2(LANES):0]    wb_lane_o,
  output logic                      stall_o
);
  localparam int PW = $clog2(LANES) + 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                  r_state;
  logic [LANES*XLEN-1:0]   r_inst;
  logic [LANES-1:0]        r_valid;
  logic [PW-1:0]           r_ptr;

  logic                    w_idle;
  logic [LANES*XLEN-1:0]   w_inst;
  logic [LANES-1:0]        w_valid;
  logic [PW-1:0]           w_ptr;
  logic [LANES*CTRL_W-1:0] w_ctrl;
  logic [LANES-1:0]        w_cf;
  logic [LANES-1:0]        w_wr;
  logic [LANES-1:0]        w_r1;
  logic [LANES-1:0]        w_r2;
  logic [4:0]              w_rd  [LANES];
  logic [4:0]              w_rs1 [LANES];
  logic [4:0]              w_rs2 [LANES];
  logic [LANES-1:0]        w_sq_valid;
  logic                    w_hit;
  logic                    w_wb_hit;
  logic [PW-1:0]           w_wb_idx;
  logic [PW-1:0]           w_cut;
  logic [LANES-1:0]        w_issue;
  logic                    w_opp;
  logic                    w_acc;
  logic                    w_load;

  // fresh bundle in IDLE, held bundle while splitting
  assign w_idle  = (r_state == IDLE);
  assign w_inst  = w_idle ? inst_i : r_inst;
  assign w_valid = w_idle ? w_sq_valid : r_valid;
  assign w_ptr   = w_idle ? '0 : r_ptr;

  for (genvar g = 0; g < LANES; g++) begin : g_dec
    decoder #(.XLEN(XLEN), .CTRL_W(CTRL_W)) u_dec (
      .i_inst   (w_inst[g*XLEN +: XLEN]),
      .o_ctrl   (w_ctrl[g*CTRL_W +: CTRL_W]),
      .o_is_cf  (w_cf[g]),
      .o_writes (w_wr[g]),
      .o_rd1    (w_r1[g]),
      .o_rd2    (w_r2[g]),
      .o_rd     (w_rd[g]),
      .o_rs1    (w_rs1[g]),
      .o_rs2    (w_rs2[g])
    );
  end

  // squash behind oldest taken branch, find oldest taken non-branch
  always_comb begin
    w_sq_valid = lane_valid_i;
    w_hit      = 1'b0;
    w_wb_hit   = 1'b0;
    w_wb_idx   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_hit)
        w_sq_valid[k] = 1'b0;
      else if (lane_valid_i[k] && pred_taken_i[k] && w_cf[k])
        w_hit = 1'b1;
    end
    for (int k = 0; k < LANES; k++) begin
      if (!w_wb_hit && w_sq_valid[k] && pred_taken_i[k] && !w_cf[k]) begin
        w_wb_hit = 1'b1;
        w_wb_idx = PW'(k);
      end
    end
  end

  // lowest lane reading a register written by an older lane of this group
  always_comb begin
    logic v_conf;
    w_cut = PW'(LANES);
    for (int k = LANES - 1; k > 0; k--) begin
      v_conf = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (j >= int'(w_ptr) && w_valid[j] && w_wr[j] &&
            ((w_r1[k] && w_rs1[k] == w_rd[j]) ||
             (w_r2[k] && w_rs2[k] == w_rd[j])))
          v_conf = 1'b1;
      end
      if (w_valid[k] && v_conf)
        w_cut = PW'(k);
    end
    for (int k = 0; k < LANES; k++)
      w_issue[k] = w_valid[k] && (k >= int'(w_ptr)) &&
                   (k < int'(w_cut));
  end

  assign w_opp      = !out_valid_o || out_ready_i;
  assign in_ready_o = w_idle && w_opp && !flush_i;
  assign stall_o    = in_valid_i && !in_ready_o;
  assign w_acc      = in_valid_i && in_ready_o;
  assign w_load     = w_idle ? (w_acc && (|w_sq_valid))
                             : (w_opp && !flush_i);

  // output register, split FSM and mispredict pulse
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state        <= IDLE;
      r_inst         <= '0;
      r_valid        <= '0;
      r_ptr          <= '0;
      out_valid_o    <= 1'b0;
      inst_o         <= '0;
      ctrl_o         <= '0;
      lane_valid_o   <= '0;
      wasnt_branch_o <= 1'b0;
      wb_lane_o      <= '0;
    end else begin
      wasnt_branch_o <= 1'b0;
      wb_lane_o      <= '0;
      if (flush_i) begin
        out_valid_o <= 1'b0;
        r_state     <= IDLE;
        r_ptr       <= '0;
      end else begin
        if (w_opp)
          out_valid_o <= w_load;
        if (w_load) begin
          inst_o       <= w_inst;
          ctrl_o       <= w_ctrl;
          lane_valid_o <= w_issue;
          if (w_cut < PW'(LANES)) begin
            r_state <= SPLIT;
            r_ptr   <= w_cut;
            r_inst  <= w_inst;
            r_valid <= w_valid;
          end else begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end
        end
        if (w_acc && w_wb_hit) begin
          wasnt_branch_o <= 1'b1;
          wb_lane_o      <= w_wb_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_bundle_stage.sv
// tb_decode_bundle_stage: random and directed checks of the decode
// stage against a bundle-level reference model.

module tb_decode_bundle_stage;
  localparam int L  = 2;
  localparam int X  = 32;
  localparam int CW = 19;

  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_ADD   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_ST    = 7'h23;

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] ADD3  = 32'h001081B3;
  localparam logic [31:0] BEQ   = 32'h00000063;
  localparam logic [31:0] ADDI5 = 32'h00500293;
  localparam logic [31:0] ADD6  = 32'h00028333;

  typedef logic [L-1:0] mask_t;
  typedef mask_t mask_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [L*X-1:0] inst = '0;
  mask_t          lv = '0;
  mask_t          pt = '0;
  logic           in_ready, out_valid, wasnt, stall;
  logic [L*X-1:0] inst_o;
  logic [L*CW-1:0] ctrl_o;
  mask_t          lane_valid_o;
  logic [1:0]     wb_lane;

  logic           iv4 = 1'b0;
  logic [127:0]   in4 = '0;
  logic [3:0]     lv4 = '0;
  logic           rdy4, ov4, wb4, stall4;
  logic [127:0]   io4;
  logic [4*CW-1:0] co4;
  logic [3:0]     lvo4;
  logic [2:0]     wbl4;

  int n_cmp = 0;
  int n_bad = 0;

  bit             m_ov = 1'b0;
  mask_t          m_mask = '0;
  logic [L*X-1:0] m_inst = '0;
  logic [L*X-1:0] m_held = '0;
  bit             m_wb = 1'b0;
  int             m_wbl = 0;
  mask_q_t        m_pend;

  decode_bundle_stage #(.LANES(L), .XLEN(X), .CTRL_W(CW)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
    .lane_valid_i(lv), .pred_taken_i(pt), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .inst_o(inst_o), .ctrl_o(ctrl_o),
    .lane_valid_o(lane_valid_o), .wasnt_branch_o(wasnt),
    .wb_lane_o(wb_lane), .stall_o(stall)
  );

  decode_bundle_stage #(.LANES(4), .XLEN(X), .CTRL_W(CW)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(1'b0),
    .in_valid_i(iv4), .in_ready_o(rdy4), .inst_i(in4),
    .lane_valid_i(lv4), .pred_taken_i(4'b0000), .out_valid_o(ov4),
    .out_ready_i(1'b1), .inst_o(io4), .ctrl_o(co4),
    .lane_valid_o(lvo4), .wasnt_branch_o(wb4),
    .wb_lane_o(wbl4), .stall_o(stall4)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_cf(logic [31:0] i);
    return i[6:0] inside {OP_BR, OP_JAL, OP_JALR};
  endfunction

  function automatic bit wr(logic [31:0] i);
    return !(i[6:0] inside {OP_BR, OP_ST}) && (i[11:7] != 5'd0);
  endfunction

  function automatic bit rd1(logic [31:0] i);
    return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic bit rd2(logic [31:0] i);
    return i[6:0] inside {OP_BR, OP_ST, OP_ADD};
  endfunction

  function automatic mask_t sq(logic [L*X-1:0] b, mask_t v, mask_t p);
    bit t = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (t) v[k] = 1'b0;
      else if (v[k] && p[k] && is_cf(b[k*X +: X])) t = 1'b1;
    end
    return v;
  endfunction

  // groups close when a lane reads a register written earlier in the group
  function automatic mask_q_t split(logic [L*X-1:0] b, mask_t v);
    mask_q_t     q;
    mask_t       cur = '0;
    logic [31:0] ws = '0;
    logic [31:0] i;
    for (int k = 0; k < L; k++) begin
      i = b[k*X +: X];
      if (v[k]) begin
        if ((rd1(i) && ws[i[19:15]]) || (rd2(i) && ws[i[24:20]])) begin
          q.push_back(cur);
          cur = '0;
          ws  = '0;
        end
        cur[k] = 1'b1;
        if (wr(i)) ws[i[11:7]] = 1'b1;
      end
    end
    if (cur != '0) q.push_back(cur);
    return q;
  endfunction

  function automatic int wb_idx(logic [L*X-1:0] b, mask_t v, mask_t p);
    for (int k = 0; k < L; k++)
      if (v[k] && p[k] && !is_cf(b[k*X +: X])) return k;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(7))
      0: r[6:0] = OP_ADDI;
      1: r[6:0] = OP_ADD;
      2: r[6:0] = OP_LUI;
      3: r[6:0] = OP_AUIPC;
      4: r[6:0] = OP_JAL;
      5: r[6:0] = OP_JALR;
      6: r[6:0] = OP_BR;
      default: r[6:0] = OP_ST;
    endcase
    r[11:7]  = 5'($urandom_range(3));
    r[19:15] = 5'($urandom_range(3));
    r[24:20] = 5'($urandom_range(3));
    return r;
  endfunction

  task automatic model_step();
    bit      opp;
    mask_q_t g;
    mask_t   s;
    int      w;
    opp  = !m_ov || out_ready;
    m_wb = 1'b0;
    if (!rst_n) begin
      m_ov = 1'b0;
      m_mask = '0;
      m_inst = '0;
      m_pend.delete();
    end else if (flush) begin
      m_ov = 1'b0;
      m_pend.delete();
    end else if (opp) begin
      if (m_pend.size() != 0) begin
        m_mask = m_pend.pop_front();
        m_inst = m_held;
        m_ov   = 1'b1;
      end else if (in_valid) begin
        s = sq(inst, lv, pt);
        g = split(inst, s);
        w = wb_idx(inst, s, pt);
        if (w >= 0) begin
          m_wb  = 1'b1;
          m_wbl = w;
        end
        if (g.size() == 0) m_ov = 1'b0;
        else begin
          m_ov   = 1'b1;
          m_mask = g.pop_front();
          m_inst = inst;
          m_held = inst;
          m_pend = g;
        end
      end else m_ov = 1'b0;
    end
  endtask

  task automatic cyc();
    bit er;
    @(negedge clk);
    if (rst_n) begin
      er = (m_pend.size() == 0) && (!m_ov || out_ready) && !flush;
      check("in_ready", in_ready, er);
      check("stall", stall, in_valid && !er);
    end
    @(posedge clk);
    #1;
    model_step();
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("lane_valid", lane_valid_o, m_mask);
      check("inst_o", inst_o, m_inst);
    end
    check("wasnt_branch", wasnt, m_wb);
    if (m_wb) check("wb_lane", wb_lane, m_wbl);
    if (!rst_n) begin
      check("rst_lane_valid", lane_valid_o, 0);
      check("rst_inst", inst_o, 0);
      check("rst_ctrl", ctrl_o, 0);
      check("rst_wb_lane", wb_lane, 0);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] i0,
                       input logic [31:0] i1, input mask_t l,
                       input mask_t p);
    in_valid = v;
    inst     = {i1, i0};
    lv       = l;
    pt       = p;
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;

    drive(1, ADDI1, ADDI2, 2'b11, 2'b00);
    cyc();
    check("pair_lv", lane_valid_o, 2'b11);
    cyc();
    check("pair_b2b", out_valid, 1'b1);

    drive(1, ADDI1, ADD3, 2'b11, 2'b00);
    cyc();
    check("raw_c1", lane_valid_o, 2'b01);
    cyc();
    check("raw_c2", lane_valid_o, 2'b10);
    drive(0, ADDI1, ADDI2, 2'b11, 2'b00);
    cyc();

    drive(1, BEQ, ADDI2, 2'b11, 2'b01);
    cyc();
    check("beq_lv", lane_valid_o, 2'b01);
    drive(1, ADDI1, ADDI2, 2'b11, 2'b01);
    cyc();
    check("wb0", wasnt, 1'b1);
    drive(1, ADDI2, ADDI1, 2'b11, 2'b10);
    cyc();
    check("wb1", wb_lane, 2'd1);
    drive(0, ADDI1, ADDI2, 2'b11, 2'b00);
    cyc();
    check("wb_pulse", wasnt, 1'b0);

    drive(1, ADDI1, ADDI2, 2'b11, 2'b00);
    cyc();
    out_ready = 1'b0;
    drive(1, ADDI2, ADDI1, 2'b11, 2'b00);
    for (int n = 0; n < 3; n++) cyc();
    out_ready = 1'b1;
    cyc();
    check("bp_load", inst_o, {ADDI1, ADDI2});

    drive(1, ADDI1, ADD3, 2'b11, 2'b00);
    cyc();
    drive(0, ADDI1, ADD3, 2'b00, 2'b00);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    cyc();

    drive(1, ADDI1, ADD3, 2'b11, 2'b00);
    cyc();
    rst_n = 1'b0;
    drive(0, ADDI1, ADD3, 2'b00, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int n = 0; n < 2500; n++) begin
      in_valid = ($urandom_range(9) < 7);
      for (int k = 0; k < L; k++) begin
        inst[k*X +: X] = rnd_inst();
        lv[k] = ($urandom_range(19) < 17);
        pt[k] = ($urandom_range(4) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(39) == 0);
      cyc();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, ADDI1, ADDI2, 2'b00, 2'b00);
    cyc();

    in4 = {ADD6, ADDI5, ADD3, ADDI1};
    lv4 = 4'hF;
    iv4 = 1'b1;
    @(negedge clk);
    check("l4_rdy0", rdy4, 1'b1);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    check("l4_g0", lvo4, 4'b0001);
    check("l4_ov0", ov4, 1'b1);
    @(negedge clk);
    check("l4_rdy1", rdy4, 1'b0);
    @(posedge clk);
    #1;
    check("l4_g1", lvo4, 4'b0110);
    @(negedge clk);
    check("l4_rdy2", rdy4, 1'b0);
    @(posedge clk);
    #1;
    check("l4_g2", lvo4, 4'b1000);
    @(negedge clk);
    check("l4_rdy3", rdy4, 1'b1);
    @(posedge clk);
    #1;
    check("l4_ov3", ov4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
